secded_stream_encoder: RTL
==========================

// Module: secded_stream_encoder
// PURPOSE
//  Streaming 16-bit SEC/DED Hamming encoder: the transmit-side counterpart of the c1908-class SEC/DED checker/corrector.
//  Accepts data words on a valid/ready input and emits 22-bit codewords on a valid/ready output, one word/cycle sustained.
//  Sits between a producer and storage/link; its codewords feed the existing decoder netlists in the benchmark flow.
// PARAMETERS
//  PIPE_STAGES  2   register stages input->output; legal values 1 or 2
//  CNT_W        16  width of the emitted-word counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      input word present
//  in_ready     out  1      encoder accepts the word this cycle
//  in_data      in   16     data word
//  out_valid    out  1      codeword present
//  out_ready    in   1      consumer accepts the codeword this cycle
//  out_cw       out  22     codeword, layout below
//  word_cnt     out  CNT_W  count of output handshakes, wraps modulo 2^CNT_W
//  inj_mask     in   22     (SECDED_INJ_EN only) bits to flip in the next accepted word
//  inj_arm      in   1      (SECDED_INJ_EN only) pulse: arm a one-shot injection
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids 0, out_valid=0, out_cw=0, word_cnt=0, in_ready=1 from the first cycle after release.
//  - Layout: out_cw[21:1] = Hamming positions 1..21; parity bits sit at positions 1,2,4,8,16; in_data[15:0] fills positions 3,5,6,7,9..15,17..21 in ascending order (bit0 -> pos3).
//    p(2^k) = XOR of data positions whose index has bit k set; out_cw[0] = XOR of out_cw[21:1] (even overall parity).
//  - Pipeline: each stage is a valid+data register. A stage loads when it is empty or its downstream accepts it this cycle.
//  - in_ready = !stage1_valid || stage1_advances (combinational on out_ready; no bubble).
//  - Parity is computed between stage1 and stage2 when PIPE_STAGES=2; with 1 stage it is computed before the single register.
//  - Latency: accepted word appears on out_cw PIPE_STAGES cycles after its input handshake when out_ready=1.
//  - Throughput: 1 word/cycle with out_ready held high. Zero data loss or duplication under arbitrary out_ready stalls.
//  - out_valid/out_cw stay stable while out_valid=1 && out_ready=0.
//  - word_cnt increments on every out_valid&&out_ready and wraps from 2^CNT_W-1 to 0 without a flag.
//  - Simultaneous accept and emit in a full pipe: both happen, occupancy unchanged.
//  - rst mid-stream: all in-flight words are discarded, word_cnt cleared, and no partial word is emitted.
// CONFIGURATION
//  SECDED_INJ_EN defined:
//    - inj_arm latches inj_mask into a pending register (re-arm overwrites).
//    - The next input handshake XORs the pending mask into that word's final codeword, then clears pending.
//    - arm and handshake in the same cycle apply the new mask to that word.
//    - Parity is computed before the flip, so a 1-bit mask gives a correctable word and a 2-bit mask a detectable one.
//  SECDED_INJ_EN undefined: inj_* ports absent; codewords are always clean.
// STRUCTURE
//  - Package secded_pkg:
//    - constants DATA_W=16, CW_W=22, NPAR=5
//    - localparam array of data-bit positions
//    - typedef codeword_t (logic [21:0])
//    - function secded_encode(data)->codeword_t
//  - One sub-module secded_parity_gen: purely combinational, 16b -> 22b using secded_pkg. Instantiated once.
//  - The top holds the stage registers, handshake logic, counter and injection logic.
// TESTING
//  1. in_data=16'h0000, out_ready=1 -> out_cw=22'h000000 two cycles later; word_cnt 0->1.
//  2. in_data=16'h0001 -> out_cw=22'h00000F.
//     in_data=16'hFFFF -> out_cw=22'h3FFFFC.
//  3. Back-to-back stream of 1000 random words, out_ready random 50% -> scoreboard vs secded_encode:
//     - in order, no drops or duplicates
//     - word_cnt=1000 at the end
//     - out_cw stable during every stall.
//  4. Set CNT_W=4 and send 17 words -> word_cnt reads 1; counter wraps at 16 with no other side effect.
//  5. Fill the pipe with out_ready=0, assert rst for 1 cycle mid-stall -> out_valid=0 immediately.
//     After release, the first emitted codeword is the first word sent after reset.
//  6. (SECDED_INJ_EN) arm with inj_mask=22'h000008, send 16'h0001 -> out_cw=22'h000007.
//     The next word is unflipped.
//     Arm with mask 22'h000006 -> the reference decoder flags a double error.

Source files
------------

// File: rtl/secded_stream_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : secded_pkg
// Purpose  : Shared constants, types and the reference encode function for
//            the 16-bit SEC/DED Hamming stream encoder.
// Contents : DATA_W, CW_W, NPAR, DATA_POS, data_t, codeword_t, secded_encode()
// Codeword : cw[21:1] are Hamming positions 1..21. Parity bits are at 1,2,4,8,16.
//            Data bits fill the remaining positions in ascending order.
//            cw[0] gives even parity over cw[21:1].
// Revision : 1.0 - initial release
// ============================================================================
package secded_pkg;

    localparam int DATA_W = 16;
    localparam int CW_W   = 22;
    localparam int NPAR   = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CW_W-1:0]   codeword_t;

    // Hamming position of each data bit, data bit 0 first.
    localparam logic [4:0] DATA_POS [DATA_W] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
    };

    function automatic codeword_t secded_encode(input data_t data);
        codeword_t cw;
        logic      par;
        cw = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cw[DATA_POS[i]] = data[i];
        end
        // Parity bits at powers of two never have bit k set unless they are
        // p(2^k) itself. That bit is still zero here, so the order of filling
        // the parity bits does not matter.
        for (int k = 0; k < NPAR; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < CW_W; pos++) begin
                if (pos[k]) begin
                    par = par ^ cw[pos];
                end
            end
            cw[1 << k] = par;
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : secded_stream_encoder_if
// Purpose  : Input and output valid/ready streams of the SEC/DED encoder.
// Signals  : in_valid, in_ready, in_data[15:0]   - data word stream
//            out_valid, out_ready, out_cw[21:0]  - codeword stream
// Modports : master - the producer/consumer side that surrounds the encoder
//            slave  - the encoder itself
// Revision : 1.0 - initial release
// ============================================================================
interface secded_stream_encoder_if;
    import secded_pkg::*;

    logic      in_valid;
    logic      in_ready;
    data_t     in_data;
    logic      out_valid;
    logic      out_ready;
    codeword_t out_cw;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_cw
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_cw
    );

endinterface
`default_nettype wire

// File: rtl/secded_stream_encoder_parity_gen.sv
`default_nettype none
// ============================================================================
// Module   : secded_parity_gen
// Purpose  : Purely combinational 16-bit data to 22-bit SEC/DED codeword
//            encoder.
// Ports    : data_i [15:0] - data word
//            cw_o   [21:0] - clean codeword, layout as in secded_pkg
// Revision : 1.0 - initial release
// ============================================================================
module secded_parity_gen
    import secded_pkg::*;
(
    input  data_t     data_i,
    output codeword_t cw_o
);

    assign cw_o = secded_encode(data_i);

endmodule
`default_nettype wire

// File: rtl/secded_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : secded_stream_encoder
// Purpose  : Streaming SEC/DED encoder. It accepts 16-bit words on a
//            valid/ready input and emits 22-bit codewords on a valid/ready
//            output. It sustains one word per cycle.
// Params   : PIPE_STAGES - register stages from input to output (1 or 2)
//            CNT_W       - width of the emitted-word counter
// Ports    : clk, rst            - clock and async active-high reset
//            bus (slave)         - in_valid/in_ready/in_data, out_valid/
//                                  out_ready/out_cw
//            word_cnt            - output handshakes, wraps modulo 2^CNT_W
//            inj_mask, inj_arm   - one-shot error injection
//                                  (SECDED_INJ_EN only)
// Macro    : SECDED_INJ_EN - adds the error-injection ports and logic
// Revision : 1.0 - initial release
// ============================================================================
module secded_stream_encoder
    import secded_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    secded_stream_encoder_if.slave bus,
    output logic [CNT_W-1:0]       word_cnt
`ifdef SECDED_INJ_EN
    ,
    input  logic [CW_W-1:0]        inj_mask,
    input  logic                   inj_arm
`endif
);

    logic             w_in_hs;
    logic             w_out_hs;
    codeword_t        w_hs_mask;   // flip mask attached to the word accepted this cycle
    data_t            w_enc_data;
    codeword_t        w_enc_cw;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign w_in_hs  = bus.in_valid && bus.in_ready;
    assign w_out_hs = bus.out_valid && bus.out_ready;

    // ------------------------------------------------------------------
    // Error injection: a pending mask waits for the next input handshake.
    // An arm in the same cycle as a handshake takes effect on that word.
    // ------------------------------------------------------------------
`ifdef SECDED_INJ_EN
    codeword_t inj_pend_q;
    codeword_t inj_pend_d;

    always_comb begin
        inj_pend_d = inj_pend_q;
        w_hs_mask  = inj_arm ? inj_mask : inj_pend_q;
        if (w_in_hs) begin
            inj_pend_d = '0;
        end else if (inj_arm) begin
            inj_pend_d = inj_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_pend_q <= '0;
        end else begin
            inj_pend_q <= inj_pend_d;
        end
    end
`else
    assign w_hs_mask = '0;
`endif

    secded_parity_gen u_parity_gen (
        .data_i (w_enc_data),
        .cw_o   (w_enc_cw)
    );

    // ------------------------------------------------------------------
    // Pipeline. Each stage loads when it is empty or its downstream takes
    // its contents this cycle. The flip mask travels with its word and is
    // applied after parity generation.
    // ------------------------------------------------------------------
    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic      s1_valid_q, s1_valid_d;
            data_t     s1_data_q,  s1_data_d;
            codeword_t s1_mask_q,  s1_mask_d;
            logic      s2_valid_q, s2_valid_d;
            codeword_t s2_cw_q,    s2_cw_d;
            logic      w_s2_load;

            assign w_s2_load     = !s2_valid_q || bus.out_ready;
            assign bus.in_ready  = !s1_valid_q || w_s2_load;
            assign w_enc_data    = s1_data_q;
            assign bus.out_valid = s2_valid_q;
            assign bus.out_cw    = s2_cw_q;

            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_data_d  = s1_data_q;
                s1_mask_d  = s1_mask_q;
                s2_valid_d = s2_valid_q;
                s2_cw_d    = s2_cw_q;
                if (w_s2_load) begin
                    s2_valid_d = s1_valid_q;
                    if (s1_valid_q) begin
                        s2_cw_d = w_enc_cw ^ s1_mask_q;
                    end
                end
                if (bus.in_ready) begin
                    s1_valid_d = bus.in_valid;
                    if (bus.in_valid) begin
                        s1_data_d = bus.in_data;
                        s1_mask_d = w_hs_mask;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_mask_q  <= '0;
                    s2_valid_q <= 1'b0;
                    s2_cw_q    <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                    s1_mask_q  <= s1_mask_d;
                    s2_valid_q <= s2_valid_d;
                    s2_cw_q    <= s2_cw_d;
                end
            end
        end else begin : g_one_stage
            // Any PIPE_STAGES value other than 2 builds the single-register form.
            logic      s1_valid_q, s1_valid_d;
            codeword_t s1_cw_q,    s1_cw_d;

            assign bus.in_ready  = !s1_valid_q || bus.out_ready;
            assign w_enc_data    = bus.in_data;
            assign bus.out_valid = s1_valid_q;
            assign bus.out_cw    = s1_cw_q;

            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_cw_d    = s1_cw_q;
                if (bus.in_ready) begin
                    s1_valid_d = bus.in_valid;
                    if (bus.in_valid) begin
                        s1_cw_d = w_enc_cw ^ w_hs_mask;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_cw_q    <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_cw_q    <= s1_cw_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Emitted-word counter. It wraps silently.
    // ------------------------------------------------------------------
    assign cnt_d    = w_out_hs ? cnt_q + 1'b1 : cnt_q;
    assign word_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire
